bnn_maxpool: RTL and testbench
==============================

Name: bnn_maxpool

Overview:
- Downstream stage of the binary convolution engine.
- Consumes the convolved binary rows one 16-bit word per row and applies 2x2 binary max-pooling, which is a logical OR over a 2x2 window.
- Writes the pooled rows to the output SRAM through a write-port interface matching the convolution stage's.
- Each image ends with `in_last`. A `flush` command writes the terminator word that the next layer's reader stops on.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, row word width; bit 0 is column 0.
- BASE_ADDR, 12'h000, first output SRAM address after `run`.
- TERM_WORD, 16'h00FF, end-of-stream marker written on flush.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  pulse; rewinds the write address to BASE_ADDR and starts a new stream.
- busy  output  1  high from the cycle after `run` until the terminator write completes.
- in_valid  input  1  row word valid.
- in_ready  output  1  block can accept a row.
- in_data  input  16  convolved row; bits at or above `in_width` are ignored.
- in_width  input  5  valid columns in the row (8, 10 or 14); sampled on the first row of each image.
- in_last  input  1  qualifies the final row of the image.
- flush  input  1  pulse; write TERM_WORD after pending rows.
- dut_sram_write_address  output  12  output SRAM address.
- dut_sram_write_data  output  16  pooled row.
- wr_enable  output  1  one-cycle write strobe.
- done  output  1  one-cycle pulse when the terminator is written.

Behaviour:
- Reset clears all of the following:
  - state goes to IDLE;
  - busy, wr_enable, done and in_ready are 0;
  - the write address is BASE_ADDR and the write data is 0;
  - the held row and latched width are 0.
- A row is accepted on any cycle where `in_valid && in_ready` (a transfer).
- States:
  - IDLE: in_ready=0. `run` moves to PAIR0 and loads the address with BASE_ADDR.
  - PAIR0: in_ready=1.
    - A transfer with in_last=0 stores the masked row in `hold` and latches `in_width`; go to PAIR1.
    - A transfer with in_last=1 schedules a write of the row pooled alone; stay in PAIR0.
    - `flush` with no transfer goes to TERM.
  - PAIR1: in_ready=1.
    - A transfer schedules a write of `pool(hold | row)` and returns to PAIR0, including when in_last=1.
    - `flush` with no transfer goes to TERM (see boundary rules).
  - TERM: in_ready=0. Issue a TERM_WORD write, pulse `done`, then go to IDLE.
- pool(r) definition:
  - output bit j = r[2j] | r[2j+1] for j < floor(w/2), where w is the latched width;
  - all higher output bits are 0;
  - an odd w drops the last column;
  - widths 8, 10 and 14 therefore give 4, 5 and 7 pooled bits.
  - w > 16 is treated as 16.
- Writes are registered: a write is scheduled in cycle N and wr_enable=1 in cycle N+1, with the address and data stable in that cycle.
- The first write of a stream goes to BASE_ADDR. Each write is followed by an address increment, so the address points at the next free word.
- Throughput is one row per cycle. in_ready never drops in PAIR0 or PAIR1, so writes are never back-pressured.
- Address wrap: the address rolls from 12'hFFF to 12'h000 silently.
- Boundary rules:
  - in_width is latched only on the first row of a pair. The second row's width is ignored.
  - `flush` arriving in the same cycle as a transfer: process the row first, then go to TERM on the next cycle.
  - `flush` in PAIR1 with no transfer: write `pool(hold)` first, then go to TERM.
  - `run` while busy restarts the stream: `hold` is discarded, the address is reloaded and no terminator is written.
  - `reset` mid-operation aborts immediately to the reset values.
  - An in_valid pulse in IDLE or TERM is ignored (in_ready=0).

Optional Feature:
- Macro: BNN_POOL_ONES_COUNT_EN.
- When defined, add output `ones_count[15:0]` holding the running popcount of all pooled row words written since `run`.
  - The count updates in the same cycle as each pooled wr_enable.
  - The TERM_WORD write is excluded.
  - The count saturates at 16'hFFFF.
  - Reset clears it to 0.
- When undefined, the port and its logic are absent and the behaviour is otherwise identical.

Test Plan:
1. Basic pair: reset, run, width=8, rows 16'h00A5 then 16'h005A (in_last on the second) -> one write, addr 0x000, data 16'h000F.
2. Odd row count: width=10, rows 16'h0003, 16'h0000, 16'h0200 (in_last) -> writes 16'h0001 at 0x000 and 16'h0010 at 0x001.
3. Width masking: width=14 with in_data=16'hC000 only -> data 16'h0000. Separately, width=14 with 16'h3000 paired with 16'h0000 -> data 16'h0040.
4. Flush mid-pair: width=8, one row 16'h0081, then flush -> write 16'h0009, then TERM_WORD 16'h00FF at the next address. `done` pulses once and busy falls.
5. Back-to-back: 6 rows on consecutive cycles with in_valid held high -> in_ready stays 1, three writes on addresses 0,1,2 with no gaps.
6. Restart and reset: run issued mid-pair -> the held row is dropped and the next write lands at BASE_ADDR. Reset asserted for one cycle mid-stream -> all outputs read 0 on the next cycle. With BNN_POOL_ONES_COUNT_EN, scenario 2 gives ones_count=2.

Source files
------------

// File: rtl/bnn_maxpool.sv
// bnn_maxpool: 2x2 binary max-pool (OR) of 16-bit convolved rows into output SRAM.
// Define BNN_POOL_ONES_COUNT_EN to add the saturating ones_count popcount output.
module bnn_maxpool #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] TERM_WORD = DATA_W'(16'h00FF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_width,
    input  logic              in_last,
    input  logic              flush,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              wr_enable,
    output logic              done
`ifdef BNN_POOL_ONES_COUNT_EN
    ,
    output logic [15:0]       ones_count
`endif
);

    typedef enum logic [1:0] {IDLE, PAIR0, PAIR1, TERM} state_t;

    state_t            state;
    logic [DATA_W-1:0] hold;
    logic [4:0]        width;
    logic              xfer;
    logic              sched_en;
    logic [DATA_W-1:0] sched_data;
    logic [DATA_W-1:0] pool_one;
    logic [DATA_W-1:0] pool_pair;
    logic [DATA_W-1:0] pool_hold;
    logic [DATA_W-1:0] row_mask;

    function automatic logic [DATA_W-1:0] pool(
        input logic [DATA_W-1:0] r,
        input logic [4:0]        w
    );
        logic [DATA_W-1:0] p;
        int                half;
        half = ((int'(w) > DATA_W) ? DATA_W : int'(w)) / 2;
        p = '0;
        for (int j = 0; j < DATA_W / 2; j++)
            p[j] = (j < half) && (r[2*j] | r[2*j+1]);
        return p;
    endfunction

    function automatic logic [DATA_W-1:0] col_mask(input logic [4:0] w);
        logic [DATA_W-1:0] m;
        for (int j = 0; j < DATA_W; j++)
            m[j] = (j < int'(w));
        return m;
    endfunction

    assign in_ready  = (state == PAIR0) || (state == PAIR1);
    assign xfer      = in_valid && in_ready;
    assign pool_one  = pool(in_data, in_width);
    assign pool_pair = pool(hold | in_data, width);
    assign pool_hold = pool(hold, width);
    assign row_mask  = col_mask(in_width);

    // A first row arriving with flush is pooled alone so nothing is lost.
    always_comb begin
        sched_en   = 1'b0;
        sched_data = pool_one;
        if (!run) begin
            case (state)
                PAIR0: sched_en = xfer && (in_last || flush);
                PAIR1: begin
                    sched_en   = xfer || flush;
                    sched_data = xfer ? pool_pair : pool_hold;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            busy                   <= 1'b0;
            wr_enable              <= 1'b0;
            done                   <= 1'b0;
            dut_sram_write_address <= BASE_ADDR;
            dut_sram_write_data    <= '0;
            hold                   <= '0;
            width                  <= '0;
        end else begin
            wr_enable <= sched_en;
            done      <= 1'b0;
            if (sched_en)
                dut_sram_write_data <= sched_data;
            if (run) begin
                state                  <= PAIR0;
                busy                   <= 1'b1;
                dut_sram_write_address <= BASE_ADDR;
                hold                   <= '0;
                width                  <= '0;
            end else begin
                if (wr_enable)
                    dut_sram_write_address <= dut_sram_write_address + ADDR_W'(1);
                unique case (state)
                    IDLE: busy <= 1'b0;
                    PAIR0: begin
                        if (xfer) begin
                            width <= in_width;
                            if (flush) begin
                                state <= TERM;
                            end else if (!in_last) begin
                                hold  <= in_data & row_mask;
                                state <= PAIR1;
                            end
                        end else if (flush) begin
                            state <= TERM;
                        end
                    end
                    PAIR1: begin
                        if (xfer || flush)
                            state <= flush ? TERM : PAIR0;
                    end
                    TERM: begin
                        wr_enable           <= 1'b1;
                        dut_sram_write_data <= TERM_WORD;
                        done                <= 1'b1;
                        state               <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef BNN_POOL_ONES_COUNT_EN
    localparam int CNT_W = $clog2(DATA_W + 1);

    function automatic logic [CNT_W-1:0] popcnt(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int j = 0; j < DATA_W; j++)
            c = c + CNT_W'(v[j]);
        return c;
    endfunction

    logic [16:0] ones_sum;

    assign ones_sum = {1'b0, ones_count} + 17'(popcnt(sched_data));

    always_ff @(posedge clk) begin
        if (reset || run)
            ones_count <= '0;
        else if (sched_en)
            ones_count <= ones_sum[16] ? 16'hFFFF : ones_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_bnn_maxpool.sv
// tb_bnn_maxpool: directed plus randomized rows checked against a pair-level
// reference model of the pooled SRAM writes.
module tb_bnn_maxpool;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [4:0]  in_width = 5'd8;
    logic        in_last = 1'b0;
    logic        flush = 1'b0;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_enable;
    logic        done;
`ifdef BNN_POOL_ONES_COUNT_EN
    logic [15:0] ones_count;
`endif

    bnn_maxpool dut (
        .clk                    (clk),
        .reset                  (reset),
        .run                    (run),
        .busy                   (busy),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_data                (in_data),
        .in_width               (in_width),
        .in_last                (in_last),
        .flush                  (flush),
        .dut_sram_write_address (wr_addr),
        .dut_sram_write_data    (wr_data),
        .wr_enable              (wr_enable),
        .done                   (done)
`ifdef BNN_POOL_ONES_COUNT_EN
        ,
        .ones_count             (ones_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [15:0] d;
        logic        term;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] rows_q[$];
    int          pair_w;
    logic [11:0] next_addr;
    int          ones_m;
    int          done_cnt;
    int          vectors;
    int          miscompares;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_pool(input logic [15:0] r, input int w);
        logic [15:0] p;
        int          n;
        n = ((w > 16) ? 16 : w) / 2;
        p = '0;
        for (int j = 0; j < n; j++)
            if (((r >> (2 * j)) & 16'h3) != 16'h0)
                p = p | (16'h1 << j);
        return p;
    endfunction

    task automatic push_wr(input logic [15:0] d, input logic term);
        exp_q.push_back('{a: next_addr, d: d, term: term});
        next_addr = next_addr + 12'd1;
    endtask

    task automatic model_row(input logic [15:0] d, input int w, input logic last);
        if (rows_q.size() == 0)
            pair_w = w;
        rows_q.push_back(d);
        if (rows_q.size() == 2) begin
            push_wr(ref_pool(rows_q[0] | rows_q[1], pair_w), 1'b0);
            rows_q.delete();
        end else if (last) begin
            push_wr(ref_pool(rows_q[0], pair_w), 1'b0);
            rows_q.delete();
        end
    endtask

    task automatic model_flush();
        if (rows_q.size() == 1)
            push_wr(ref_pool(rows_q[0], pair_w), 1'b0);
        rows_q.delete();
        push_wr(16'h00FF, 1'b1);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset && wr_enable) begin
            if (exp_q.size() == 0) begin
                check("wr_expected", 32'(wr_enable), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
                check("done_on_term", 32'(done), 32'(e.term));
`ifdef BNN_POOL_ONES_COUNT_EN
                if (!e.term) begin
                    ones_m = ones_m + $countones(e.d);
                    if (ones_m > 65535)
                        ones_m = 65535;
                end
                check("ones_count", 32'(ones_count), 32'(ones_m));
`endif
            end
        end
        if (!reset && done)
            done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            flush = 1'b0;
            in_last = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic do_run();
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        run = 1'b1;
        @(posedge clk);
        check("q_empty_at_run", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rows_q.delete();
        next_addr = 12'h000;
        ones_m = 0;
        @(negedge clk);
        run = 1'b0;
        check("busy_after_run", 32'(busy), 32'd1);
    endtask

    task automatic send_row(input logic [15:0] d, input int w,
                            input logic last, input logic fl);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        in_width = 5'(w);
        in_last = last;
        flush = fl;
        check("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        model_row(d, w, last);
        if (fl)
            model_flush();
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_pulse", 32'(done_cnt - d0), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("busy_low", 32'(busy), 32'd0);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_flush();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        model_flush();
        @(negedge clk);
        flush = 1'b0;
        wait_done(d0);
    endtask

    task automatic flush_with_row(input logic [15:0] d, input int w, input logic last);
        int d0;
        d0 = done_cnt;
        send_row(d, w, last, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        wait_done(d0);
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        rows_q.delete();
        next_addr = 12'h000;
        ones_m = 0;
        @(negedge clk);
        check({tag, "_wr_enable"}, 32'(wr_enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_data"}, 32'(wr_data), 32'd0);
`ifdef BNN_POOL_ONES_COUNT_EN
        check({tag, "_ones"}, 32'(ones_count), 32'd0);
`endif
        reset = 1'b0;
    endtask

    function automatic int pick_w();
        int ws[5];
        ws = '{8, 10, 14, 16, 20};
        return ws[$urandom_range(0, 4)];
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int mode;
        int nrows;
        next_addr = 12'h000;
        repeat (2) @(posedge clk);
        reset_check("rst");

        do_run();
        send_row(16'h00A5, 8, 1'b0, 1'b0);
        send_row(16'h005A, 8, 1'b1, 1'b0);
        idle(2);
        do_flush();

        do_run();
        send_row(16'h0003, 10, 1'b0, 1'b0);
        send_row(16'h0000, 10, 1'b0, 1'b0);
        send_row(16'h0200, 10, 1'b1, 1'b0);
        idle(3);
`ifdef BNN_POOL_ONES_COUNT_EN
        check("ones_after_t2", 32'(ones_count), 32'd2);
`endif
        do_flush();

        do_run();
        send_row(16'hC000, 14, 1'b1, 1'b0);
        send_row(16'h3000, 14, 1'b0, 1'b0);
        send_row(16'h0000, 14, 1'b1, 1'b0);
        idle(2);
        do_flush();

        do_run();
        send_row(16'h0081, 8, 1'b0, 1'b0);
        do_flush();

        do_run();
        for (int i = 0; i < 6; i++)
            send_row(16'($urandom), pick_w(), 1'(i == 5), 1'b0);
        send_row(16'h0003, 8, 1'b0, 1'b0);
        send_row(16'h0300, 14, 1'b1, 1'b0);
        idle(2);
        do_flush();

        do_run();
        flush_with_row(16'h00C0, 8, 1'b0);

        do_run();
        send_row(16'hFFFF, 8, 1'b0, 1'b0);
        do_run();
        send_row(16'h0001, 8, 1'b1, 1'b0);
        send_row(16'h00F0, 8, 1'b0, 1'b0);
        idle(2);
        reset_check("midrst");
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 16'hFFFF;
            check("idle_in_ready", 32'(in_ready), 32'd0);
        end
        idle(2);

        do_run();
        n = 4097 * 2;
        for (int i = 0; i < n; i++)
            send_row(16'($urandom), 8, 1'(i == n - 1), 1'b0);
        idle(2);
        do_flush();

        do_run();
        for (int img = 0; img < 40; img++) begin
            nrows = $urandom_range(1, 7);
            mode = $urandom_range(0, 5);
            for (int r = 0; r < nrows; r++) begin
                if ($urandom_range(0, 3) == 0)
                    idle(1);
                if (r == nrows - 1 && mode == 0)
                    flush_with_row(16'($urandom), pick_w(), 1'($urandom_range(0, 1)));
                else
                    send_row(16'($urandom), pick_w(),
                             1'(r == nrows - 1 && mode != 1), 1'b0);
            end
            if (mode == 1)
                do_flush();
            if (mode <= 1)
                do_run();
        end
        idle(2);
        do_flush();

        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
